ldpc_3gpp_enc_mm_ctrl: RTL and testbench
========================================

Name: ldpc_3gpp_enc_mm_ctrl

Overview:
Sequencer for the encoder single-port-RAM matrix multiplier.
- Per job: loads one Zc-bit systematic block into the multiplier (write phase).
- Then walks a list of Hb entries from an external Hb ROM, issuing one read cycle per entry.
- Generates the read strobes (sof/sop/eop/eof) consumed downstream by the parity accumulator.
- Sits between the encoder top-level input buffer/Hb ROM and the matrix multiplier.

Parameters:
pWORD_W, 8, width of word counter; must equal the multiplier address width.
pHB_ADDR_W, 8, Hb ROM address width.
pHB_NUM_W, 8, width of Hb entry count.

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-high
iclkena  in  1  clock enable; all state frozen when low
istart  in  1  job start pulse; sampled only in IDLE
iword_num  in  pWORD_W  words per block (Zc/pDAT_W), sampled at istart
ihb_base  in  pHB_ADDR_W  first Hb ROM address of job, sampled at istart
ihb_num  in  pHB_NUM_W  Hb entries in job, sampled at istart
ival  in  1  write data valid from input buffer
idat  in  dat_t  write data
ordy  out  1  ready for write data; high only in WRITE
ohb_addr  out  pHB_ADDR_W  Hb ROM address; ROM read latency 1 tick
ihb  in  mm_hb_value_t  Hb ROM data
owrite, owstart  out  1 each  multiplier write controls
owdat  out  dat_t  multiplier write data (idat pass-through)
oread, orstart, orval  out  1 each  multiplier read controls
orHb  out  mm_hb_value_t  Hb value for current read cycle
orstrb  out  strb_t  strobes {sof,sop,eop,eof}, meaningful while orval
obusy  out  1  job in progress
odone  out  1  one-tick pulse at job end

Behaviour:
- Reset: IDLE; counters 0; every output 0, including ordy, obusy, odone, orstrb and orHb.
- FSM states: IDLE, WRITE, FETCH, READ, DONE.
- IDLE:
  - istart: latch parameters, set obusy, go to WRITE.
  - iword_num=0 is clamped to 1.
- WRITE:
  - ordy=1. Each ival&ordy gives owrite=1, owdat=idat.
  - owstart=1 on the first accepted word only.
  - Word counter counts accepted words; gaps (ival=0) are allowed and produce owrite=0.
  - After word iword_num-1 is accepted: go to FETCH, or to DONE if ihb_num=0.
- FETCH (1 tick): ohb_addr = ihb_base + entry index. Go to READ.
- READ (iword_num+1 ticks, oread=1 throughout):
  - Tick 0: orstart=1, orval=0. orHb takes ihb combinationally and is registered for the rest of the cycle (stable for the whole read cycle).
  - Ticks 1..iword_num: orval=1.
  - sop on tick 1; eop on tick iword_num.
  - sof on tick 1 of entry 0; eof on the eop tick of the last entry.
  - Masked entries (orHb.is_masked) are issued normally.
  - Last tick: increment entry index. Go to FETCH, or to DONE after entry ihb_num-1.
- DONE (1 tick): odone=1, obusy drops. Next state IDLE. A new job is accepted from the following tick.
- obusy=1 in WRITE, FETCH, READ and DONE.
- istart outside IDLE is ignored.
- iused_zc to the multiplier is not driven here; the top level holds it constant during the job.
- Entry index and address arithmetic wrap modulo 2^pHB_ADDR_W.
- Reset mid-job aborts immediately: no odone, and multiplier outputs in flight are discarded by the top level.
- Single-word case (iword_num=1): sop and eop on the same tick; sof/sop/eop/eof all set for a 1-entry job.

Optional Feature:
LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
- Defined:
  - Next ohb_addr is issued on the last READ tick, and FETCH is skipped between entries.
  - Reads are back-to-back: orstart of entry k+1 follows the eop tick of entry k directly.
  - Job read time is ihb_num*(iword_num+1) ticks; FETCH is used only before entry 0.
- Undefined: one FETCH tick precedes every entry; read time is ihb_num*(iword_num+2) ticks.

Decomposition:
- strb_t, mm_hb_value_t, dat_t and hb_zc_t stay in the existing shared encoder types package. The FSM state enum is local.
- No sub-module; single FSM plus word and entry counters.

Test Plan:
1. iword_num=4, ihb_num=2, ival always high:
   - owrite for 4 ticks, owstart on the first.
   - FETCH, then READ of 5 ticks (orstart, then orval x4), twice.
   - sof on the first orval; eof on the 8th orval.
   - odone 1 tick after the last READ tick.
2. ival with a pattern 1,0,1,1,0,1 -> exactly 4 owrite ticks; owdat matches the accepted idat order; FETCH starts after the 4th accepted word.
3. ihb_num=0 -> WRITE then DONE; no oread; odone pulses.
4. iword_num=1, ihb_num=1 -> a single orval tick with sof/sop/eop/eof all 1.
5. ireset asserted mid-READ -> all outputs 0 immediately; no odone. A subsequent istart runs a clean job.
6. With the PREFETCH macro, ihb_num=3, iword_num=2 -> orstart ticks spaced exactly 3 apart. Without it, spaced 4 apart.

Source files
------------

// File: rtl/ldpc_3gpp_enc_mm_ctrl_pkg.sv
// Shared encoder types used by the matrix-multiplier sequencer and its neighbours.
package ldpc_3gpp_enc_mm_ctrl_pkg;

   localparam int unsigned DatW   = 8;
   localparam int unsigned HbZcW  = 9;

   typedef logic [DatW-1:0]  dat_t;
   typedef logic [HbZcW-1:0] hb_zc_t;

   // One Hb matrix entry: circulant shift plus a flag for all-zero sub-blocks.
   typedef struct packed {
      logic   is_masked;
      hb_zc_t shift;
   } mm_hb_value_t;

   typedef struct packed {
      logic sof;
      logic sop;
      logic eop;
      logic eof;
   } strb_t;

endpackage

// File: rtl/ldpc_3gpp_enc_mm_ctrl.sv
// Matrix-multiplier sequencer: loads one systematic block, then walks the job's Hb entries,
// issuing one read cycle per entry with sof/sop/eop/eof strobes for the parity accumulator.
// Optional macro LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN: the next Hb address is issued on the
// last read tick so read cycles run back-to-back without a FETCH tick between entries.
module ldpc_3gpp_enc_mm_ctrl
   import ldpc_3gpp_enc_mm_ctrl_pkg::*;
#(
   parameter int unsigned pWORD_W    = 8,
   parameter int unsigned pHB_ADDR_W = 8,
   parameter int unsigned pHB_NUM_W  = 8
) (
   input  logic                  iclk,
   input  logic                  ireset,
   input  logic                  iclkena,
   input  logic                  istart,
   input  logic [pWORD_W-1:0]    iword_num,
   input  logic [pHB_ADDR_W-1:0] ihb_base,
   input  logic [pHB_NUM_W-1:0]  ihb_num,
   input  logic                  ival,
   input  dat_t                  idat,
   output logic                  ordy,
   output logic [pHB_ADDR_W-1:0] ohb_addr,
   input  mm_hb_value_t          ihb,
   output logic                  owrite,
   output logic                  owstart,
   output dat_t                  owdat,
   output logic                  oread,
   output logic                  orstart,
   output logic                  orval,
   output mm_hb_value_t          orHb,
   output strb_t                 orstrb,
   output logic                  obusy,
   output logic                  odone
);

`ifdef LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
   localparam bit PrefetchEn = 1'b1;
`else
   localparam bit PrefetchEn = 1'b0;
`endif

   localparam logic [pWORD_W-1:0]   WordOne = pWORD_W'(1);
   localparam logic [pHB_NUM_W-1:0] NumOne  = pHB_NUM_W'(1);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StFetch,
      StRead,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [pWORD_W-1:0]    word_num_q, word_num_d;
   logic [pWORD_W-1:0]    word_cnt_q, word_cnt_d;
   logic [pHB_ADDR_W-1:0] hb_base_q, hb_base_d;
   logic [pHB_NUM_W-1:0]  hb_num_q, hb_num_d;
   logic [pHB_NUM_W-1:0]  entry_q, entry_d;
   mm_hb_value_t          hb_q, hb_d;

   logic accept;
   logic wr_last;
   logic rd_first;
   logic rd_last;
   logic entry_last;
   logic hb_none;
   logic prefetch;

   // Decoded conditions shared by the next-state, counter and output logic.
   always_comb begin
      accept     = (state_q == StWrite) && ival && iclkena;
      wr_last    = (word_cnt_q == (word_num_q - WordOne));
      rd_first   = (word_cnt_q == '0);
      // word_num_q is never 0, so the last read tick can never coincide with tick 0.
      rd_last    = (word_cnt_q == word_num_q);
      entry_last = (entry_q == (hb_num_q - NumOne));
      hb_none    = (hb_num_q == '0);
      prefetch   = PrefetchEn && (state_q == StRead) && rd_last && !entry_last;
   end

   // State register; everything freezes while iclkena is low.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state_q <= StIdle;
      end else if (iclkena) begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (istart) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (accept && wr_last) begin
               state_d = hb_none ? StDone : StFetch;
            end
         end
         StFetch: begin
            state_d = StRead;
         end
         StRead: begin
            if (rd_last) begin
               if (entry_last) begin
                  state_d = StDone;
               end else begin
                  state_d = PrefetchEn ? StRead : StFetch;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Job parameters, word/tick counter, entry index and the held Hb value.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         word_num_q <= '0;
         word_cnt_q <= '0;
         hb_base_q  <= '0;
         hb_num_q   <= '0;
         entry_q    <= '0;
         hb_q       <= '0;
      end else if (iclkena) begin
         word_num_q <= word_num_d;
         word_cnt_q <= word_cnt_d;
         hb_base_q  <= hb_base_d;
         hb_num_q   <= hb_num_d;
         entry_q    <= entry_d;
         hb_q       <= hb_d;
      end
   end

   // Counter next-state; the word counter doubles as the read tick counter.
   always_comb begin
      word_num_d = word_num_q;
      word_cnt_d = word_cnt_q;
      hb_base_d  = hb_base_q;
      hb_num_d   = hb_num_q;
      entry_d    = entry_q;
      hb_d       = hb_q;
      unique case (state_q)
         StIdle: begin
            if (istart) begin
               word_num_d = (iword_num == '0) ? WordOne : iword_num;
               hb_base_d  = ihb_base;
               hb_num_d   = ihb_num;
               word_cnt_d = '0;
               entry_d    = '0;
            end
         end
         StWrite: begin
            if (accept) begin
               word_cnt_d = wr_last ? '0 : word_cnt_q + WordOne;
            end
         end
         StRead: begin
            if (rd_first) begin
               hb_d = ihb;
            end
            if (rd_last) begin
               word_cnt_d = '0;
               entry_d    = entry_q + NumOne;
            end else begin
               word_cnt_d = word_cnt_q + WordOne;
            end
         end
         StFetch, StDone: begin
         end
         default: begin
         end
      endcase
   end

   // Outputs; all of them are zero in IDLE so reset leaves every output low.
   always_comb begin
      ordy     = 1'b0;
      owrite   = 1'b0;
      owstart  = 1'b0;
      owdat    = '0;
      oread    = 1'b0;
      orstart  = 1'b0;
      orval    = 1'b0;
      orHb     = '0;
      orstrb   = '0;
      ohb_addr = '0;
      unique case (state_q)
         StWrite: begin
            ordy    = 1'b1;
            owrite  = accept;
            owstart = accept && (word_cnt_q == '0);
            owdat   = accept ? idat : '0;
         end
         StFetch: begin
            ohb_addr = hb_base_q + pHB_ADDR_W'(entry_q);
         end
         StRead: begin
            oread      = 1'b1;
            orstart    = rd_first;
            orval      = !rd_first;
            // ROM data is valid on tick 0 only; hold it for the rest of the read cycle.
            orHb       = rd_first ? ihb : hb_q;
            orstrb.sop = (word_cnt_q == WordOne);
            orstrb.eop = rd_last;
            orstrb.sof = orstrb.sop && (entry_q == '0);
            orstrb.eof = orstrb.eop && entry_last;
            ohb_addr   = hb_base_q + pHB_ADDR_W'(entry_q) + pHB_ADDR_W'(prefetch);
         end
         StIdle, StDone: begin
         end
         default: begin
         end
      endcase
      obusy = (state_q != StIdle);
      odone = (state_q == StDone);
   end

endmodule

// File: tb/tb_ldpc_3gpp_enc_mm_ctrl.sv
// Self-checking bench for ldpc_3gpp_enc_mm_ctrl; follows LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN.
module tb_ldpc_3gpp_enc_mm_ctrl;
   import ldpc_3gpp_enc_mm_ctrl_pkg::*;

`ifdef LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
   localparam bit Pf = 1'b1;
`else
   localparam bit Pf = 1'b0;
`endif
   localparam int ObsW = 38;

   logic         iclk = 1'b0;
   logic         ireset;
   logic         iclkena;
   logic         istart;
   logic [7:0]   iword_num;
   logic [7:0]   ihb_base;
   logic [7:0]   ihb_num;
   logic         ival;
   dat_t         idat;
   logic         ordy;
   logic [7:0]   ohb_addr;
   mm_hb_value_t ihb;
   logic         owrite;
   logic         owstart;
   dat_t         owdat;
   logic         oread;
   logic         orstart;
   logic         orval;
   mm_hb_value_t orHb;
   strb_t        orstrb;
   logic         obusy;
   logic         odone;

   int vectors     = 0;
   int miscompares = 0;

   mm_hb_value_t rom [256];

   int   obs_start[$];
   dat_t obs_wdat[$];
   dat_t exp_wdat[$];
   int   obs_nwrite;
   int   obs_nread;
   int   obs_ndone;
   int   obs_allstrb;

   ldpc_3gpp_enc_mm_ctrl dut (
      .iclk      (iclk),
      .ireset    (ireset),
      .iclkena   (iclkena),
      .istart    (istart),
      .iword_num (iword_num),
      .ihb_base  (ihb_base),
      .ihb_num   (ihb_num),
      .ival      (ival),
      .idat      (idat),
      .ordy      (ordy),
      .ohb_addr  (ohb_addr),
      .ihb       (ihb),
      .owrite    (owrite),
      .owstart   (owstart),
      .owdat     (owdat),
      .oread     (oread),
      .orstart   (orstart),
      .orval     (orval),
      .orHb      (orHb),
      .orstrb    (orstrb),
      .obusy     (obusy),
      .odone     (odone)
   );

   always #5 iclk = ~iclk;

   // Hb ROM with one tick of read latency.
   always @(posedge iclk) ihb <= rom[ohb_addr];

   function automatic logic [ObsW-1:0] pack_obs();
      return {ordy, owrite, owstart, owdat, oread, orstart, orval, orHb, orstrb,
              obusy, odone, ohb_addr};
   endfunction

   // Ticks from end of write phase to the DONE tick.
   function automatic int total_rd(input int wq, input int hn);
      if (Pf) return (hn == 0) ? 0 : 1 + hn * (wq + 1);
      return hn * (wq + 2);
   endfunction

   // Expected outputs r ticks after the write phase, from the per-entry schedule.
   function automatic logic [ObsW-1:0] exp_rd(input int r, input int wq, input int hn,
                                              input int base);
      int           k, t;
      bit           fetch, done;
      logic         rd, rs, rv, dn;
      logic [7:0]   addr;
      strb_t        s;
      mm_hb_value_t hb;
      done = (r == total_rd(wq, hn));
      fetch = 0; k = 0; t = 0;
      rd = 0; rs = 0; rv = 0; s = '0; hb = '0; addr = '0;
      if (!done) begin
         if (Pf) begin
            if (r == 0) fetch = 1;
            else begin
               k = (r - 1) / (wq + 1);
               t = (r - 1) % (wq + 1);
            end
         end else begin
            k = r / (wq + 2);
            if (r % (wq + 2) == 0) fetch = 1;
            else t = r % (wq + 2) - 1;
         end
         addr = 8'(base + k);
         if (!fetch) begin
            rd = 1; rs = (t == 0); rv = (t != 0);
            hb = rom[addr];
            s.sop = (t == 1);
            s.eop = (t == wq);
            s.sof = s.sop && (k == 0);
            s.eof = s.eop && (k == hn - 1);
            if (Pf && t == wq && k != hn - 1) addr = 8'(base + k + 1);
         end
      end
      dn = done;
      return {1'b0, 1'b0, 1'b0, 8'h00, rd, rs, rv, hb, s, 1'b1, dn, addr};
   endfunction

   // Runs one full job. mode 0: ival always high, 1: random ival, 2: pattern 1,0,1,1,0,1.
   task automatic drive_job(input int wn, input int hn, input int base, input int mode,
                            input bit ce_rand);
      int              wq;
      int              acc, r, cyc, total;
      bit              w, ce, fin, done_now;
      logic [ObsW-1:0] e, a;
      int              pat [6] = '{1, 0, 1, 1, 0, 1};
      wq = (wn == 0) ? 1 : wn;
      total = total_rd(wq, hn);
      acc = 0; r = 0; cyc = 0;
      obs_start.delete(); obs_wdat.delete(); exp_wdat.delete();
      obs_nwrite = 0; obs_nread = 0; obs_ndone = 0; obs_allstrb = 0;

      @(posedge iclk); #1;
      istart = 1; iword_num = 8'(wn); ihb_base = 8'(base); ihb_num = 8'(hn);
      ival = 0; iclkena = 1; idat = 8'($urandom);
      #3;
      a = pack_obs();
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL idle_start: got %h want %h", a, {ObsW{1'b0}});
      end

      while (acc < wq) begin
         @(posedge iclk); #1;
         istart = ($urandom_range(0, 3) == 0);
         iword_num = 8'($urandom); ihb_base = 8'($urandom); ihb_num = 8'($urandom);
         ce = !ce_rand || ($urandom_range(0, 4) != 0);
         iclkena = ce;
         case (mode)
            0:       ival = 1'b1;
            1:       ival = 1'($urandom_range(0, 1));
            default: ival = 1'(pat[cyc % 6]);
         endcase
         idat = 8'($urandom);
         cyc++;
         #3;
         w = ival && ce;
         e = {1'b1, w, w && (acc == 0), w ? idat : 8'h00, 3'b000, 10'b0, 4'b0,
              1'b1, 1'b0, 8'h00};
         a = pack_obs();
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL write acc=%0d: got %h want %h", acc, a, e);
         end
         if (owrite) begin
            obs_nwrite++;
            obs_wdat.push_back(owdat);
         end
         if (w) begin
            exp_wdat.push_back(idat);
            acc++;
         end
      end

      fin = 0;
      while (!fin) begin
         @(posedge iclk); #1;
         done_now = (r == total);
         ce = !ce_rand || ($urandom_range(0, 4) != 0);
         iclkena = ce;
         istart = done_now ? 1'b0 : 1'($urandom_range(0, 1));
         ival = 1'($urandom_range(0, 1));
         idat = 8'($urandom);
         #3;
         e = exp_rd(r, wq, hn, base);
         a = pack_obs();
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL read r=%0d w=%0d h=%0d: got %h want %h", r, wq, hn, a, e);
         end
         if (oread) obs_nread++;
         if (orval && orstrb == 4'hF) obs_allstrb++;
         if (ce) begin
            if (orstart) obs_start.push_back(r);
            if (odone) obs_ndone++;
            if (done_now) fin = 1;
            else r++;
         end
      end
      istart = 0;
      iclkena = 1;
   endtask

   task automatic test_reset();
      logic [ObsW-1:0] a;
      ireset = 1; iclkena = 1; istart = 1; ival = 1; idat = 8'hA5;
      iword_num = 8'd3; ihb_base = 8'd7; ihb_num = 8'd2;
      #2;
      a = pack_obs();
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL reset_async: got %h want 0", a);
      end
      repeat (3) @(posedge iclk);
      #4;
      a = pack_obs();
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL reset_held: got %h want 0", a);
      end
      #1 ireset = 0; istart = 0; ival = 0;
   endtask

   task automatic test_basic();
      drive_job(4, 2, int'($urandom_range(0, 255)), 0, 0);
      vectors++;
      if (obs_nwrite !== 4) begin
         miscompares++;
         $display("FAIL basic_nwrite: got %0d want 4", obs_nwrite);
      end
      vectors++;
      if (obs_start.size() !== 2) begin
         miscompares++;
         $display("FAIL basic_nstart: got %0d want 2", obs_start.size());
      end else begin
         vectors++;
         if (obs_start[1] - obs_start[0] !== (Pf ? 5 : 6)) begin
            miscompares++;
            $display("FAIL basic_gap: got %0d want %0d", obs_start[1] - obs_start[0],
                     Pf ? 5 : 6);
         end
      end
      vectors++;
      if (obs_ndone !== 1) begin
         miscompares++;
         $display("FAIL basic_done: got %0d want 1", obs_ndone);
      end
   endtask

   task automatic test_gaps();
      drive_job(4, 1, int'($urandom_range(0, 255)), 2, 0);
      vectors++;
      if (obs_nwrite !== 4 || obs_wdat.size() !== exp_wdat.size()) begin
         miscompares++;
         $display("FAIL gaps_nwrite: got %0d want 4", obs_nwrite);
      end else begin
         foreach (exp_wdat[i]) begin
            vectors++;
            if (obs_wdat[i] !== exp_wdat[i]) begin
               miscompares++;
               $display("FAIL gaps_wdat[%0d]: got %h want %h", i, obs_wdat[i], exp_wdat[i]);
            end
         end
      end
   endtask

   task automatic test_no_entries();
      drive_job(3, 0, int'($urandom_range(0, 255)), 1, 0);
      vectors++;
      if (obs_nread !== 0 || obs_ndone !== 1) begin
         miscompares++;
         $display("FAIL no_entries: got reads=%0d dones=%0d want 0 and 1", obs_nread, obs_ndone);
      end
   endtask

   task automatic test_single();
      drive_job(1, 1, int'($urandom_range(0, 255)), 0, 0);
      vectors++;
      if (obs_allstrb !== 1) begin
         miscompares++;
         $display("FAIL single_strb: got %0d all-strobe ticks want 1", obs_allstrb);
      end
      drive_job(0, 2, int'($urandom_range(0, 255)), 0, 0);
      vectors++;
      if (obs_nwrite !== 1) begin
         miscompares++;
         $display("FAIL zero_word_clamp: got %0d writes want 1", obs_nwrite);
      end
   endtask

   task automatic test_reset_mid_read();
      bit              seen;
      int              n;
      logic [ObsW-1:0] a;
      @(posedge iclk); #1;
      istart = 1; iword_num = 8'd3; ihb_base = 8'h40; ihb_num = 8'd2;
      iclkena = 1; ival = 1; idat = 8'($urandom);
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge iclk); #1;
         istart = 0; idat = 8'($urandom);
         #3;
         if (orval) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL rst_mid_reach_read: got no orval within 30 ticks want orval");
      end
      #1 ireset = 1;
      #1;
      a = pack_obs();
      vectors++;
      if (a !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got %h want 0", a);
      end
      n = 0;
      repeat (3) begin
         @(posedge iclk); #4;
         if (odone || obusy) n++;
      end
      vectors++;
      if (n !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_no_done: got %0d busy/done ticks want 0", n);
      end
      #1 ireset = 0; ival = 0;
      drive_job(2, 1, 8'hF0, 0, 0);
      vectors++;
      if (obs_ndone !== 1) begin
         miscompares++;
         $display("FAIL rst_mid_recover: got %0d dones want 1", obs_ndone);
      end
   endtask

   task automatic test_spacing();
      drive_job(2, 3, int'($urandom_range(0, 255)), 0, 0);
      vectors++;
      if (obs_start.size() !== 3) begin
         miscompares++;
         $display("FAIL spacing_nstart: got %0d want 3", obs_start.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_start[i+1] - obs_start[i] !== (Pf ? 3 : 4)) begin
               miscompares++;
               $display("FAIL spacing[%0d]: got %0d want %0d", i,
                        obs_start[i+1] - obs_start[i], Pf ? 3 : 4);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_job(2, 2, int'($urandom_range(0, 255)), 0, 0);
      drive_job(3, 1, int'($urandom_range(0, 255)), 0, 0);
      vectors++;
      if (obs_ndone !== 1 || obs_nwrite !== 3) begin
         miscompares++;
         $display("FAIL back_to_back: got dones=%0d writes=%0d want 1 and 3",
                  obs_ndone, obs_nwrite);
      end
   endtask

   task automatic test_random();
      int base;
      for (int j = 0; j < 12; j++) begin
         base = (j % 2 == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255));
         drive_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), base, 1, 1);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = mm_hb_value_t'($urandom);
      test_reset();
      test_basic();
      test_gaps();
      test_no_entries();
      test_single();
      test_reset_mid_read();
      test_spacing();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
